branch_resolve_queue: RTL
=========================

Name: branch_resolve_queue

Overview:
- Update-side counterpart of the branch history table.
- Records every prediction issued at fetch in program order and matches it against the actual branch outcome when the branch resolves.
- Drives the table write-back (index, taken), flags mispredicts and flushes wrong-path entries.
- Keeps saturating accuracy counters for the predictor test benches.

Parameters:
- M, 64, number of history table entries; ADDR_BITS = $clog2(M).
- DEPTH, 8, in-flight prediction entries (power of two, >= 2).
- CNT_W, 16, width of the accuracy counters.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- pred_valid  input  1  a prediction is presented this cycle.
- pred_pc  input  9  branch PC for the prediction.
- pred_taken  input  1  predicted direction.
- pred_ready  output  1  queue can accept; equals !full.
- res_valid  input  1  oldest in-flight branch resolved this cycle.
- res_taken  input  1  actual direction.
- upd_valid  output  1  one-cycle table write strobe.
- upd_index  output  ADDR_BITS  table index to update, pc[ADDR_BITS-1:0] of the resolved entry.
- upd_taken  output  1  outcome to write.
- mispredict  output  1  one-cycle pulse, coincident with upd_valid.
- occupancy  output  $clog2(DEPTH)+1  current entry count.
- total_cnt  output  CNT_W  resolved branches, saturating.
- miss_cnt  output  CNT_W  mispredicted branches, saturating.
- underflow_err  output  1  sticky: set by res_valid while empty.

Behaviour:
- Reset (reset=0, async): pointers and occupancy are 0; upd_valid, upd_index, upd_taken, mispredict, total_cnt, miss_cnt and underflow_err are all 0. pred_ready=1 once the queue is empty.
- Storage: circular FIFO of DEPTH entries {index[ADDR_BITS-1:0], pred_taken}. Write and read pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.
- Push: accepted on the edge where pred_valid && pred_ready. With pred_ready=0, pred_valid is ignored and no state changes.
- Pop: on the edge where res_valid && occupancy>0, the head entry is removed.
  - Registered outputs, visible the next cycle for exactly one cycle: upd_valid=1, upd_index=head.index, upd_taken=res_taken, mispredict=(head.pred_taken != res_taken).
- Latency: resolution to table update is 1 cycle. Prediction push to earliest possible pop is 1 cycle, so a push at edge k can be resolved at edge k+1.
- Mispredict flush: on the same edge as a mispredicting pop, occupancy is cleared to 0 and the read pointer is set equal to the write pointer.
  - A push presented in that same cycle is dropped as wrong-path.
- Simultaneous push and correct pop: both take effect and occupancy is unchanged.
  - When full, pred_ready=0 even while a pop is occurring; there is no same-cycle full bypass.
- Empty pop: res_valid with occupancy==0 performs no pop and pulses no upd_valid. It sets underflow_err, which is cleared only by reset. A push in that cycle is still accepted.
- Counters:
  - total_cnt increments on each valid pop.
  - miss_cnt increments on each mispredicting pop.
  - Both hold at 2^CNT_W-1.
  - Counters update on the pop edge, so their new values are visible in the same cycle as upd_valid.
- Reset mid-operation clears the queue immediately. No pending upd_valid or mispredict survives reset.
- There is no combinational path from res_* to upd_*. pred_ready depends only on registered occupancy.

Test Plan:
- Reset, then push pc=0x045 taken=1 and resolve res_taken=1 the next cycle -> one cycle later upd_valid=1, upd_index=5 (M=64), upd_taken=1, mispredict=0; total_cnt=1, miss_cnt=0.
- Push 8 entries back-to-back -> occupancy=8, pred_ready=0. A 9th push is dropped. 8 correct resolutions return upd_index values in push order; the pointer wrap is then exercised by 8 more pushes and pops.
- Push 3 entries with the head predicted taken, then resolve res_taken=0 while pred_valid=1 -> mispredict=1 and upd_taken=0 next cycle; occupancy=0; the simultaneous push is dropped; miss_cnt=1.
- With occupancy=4, push and correct pop in the same cycle -> occupancy stays 4 and order is preserved.
- res_valid with an empty queue -> upd_valid stays 0, underflow_err=1 and stays 1 until reset; counters are unchanged.
- With CNT_W=4, run 20 mispredicting resolutions -> total_cnt=miss_cnt=15. Asserting reset mid-stream -> all outputs 0 asynchronously and pred_ready=1.

Source files
------------

// File: rtl/branch_resolve_queue.sv
// -----------------------------------------------------------------------------
// branch_resolve_queue
//
// Update side of the branch history table. Every prediction issued at fetch is
// queued in program order; when the oldest branch resolves, its queued
// prediction is compared with the real outcome. The result drives a one-cycle
// table write-back, flags mispredicts (flushing all younger wrong-path entries)
// and feeds two saturating accuracy counters.
//
// Ports:
//   clk           rising-edge clock
//   reset         asynchronous, active-low reset
//   pred_valid    prediction presented this cycle
//   pred_pc       branch PC of the prediction (9 bits)
//   pred_taken    predicted direction
//   pred_ready    queue can accept a prediction (not full)
//   res_valid     oldest in-flight branch resolved this cycle
//   res_taken     actual direction
//   upd_valid     one-cycle table write strobe
//   upd_index     table index to update (low PC bits of the resolved entry)
//   upd_taken     outcome to write
//   mispredict    one-cycle pulse, coincident with upd_valid
//   occupancy     number of queued predictions
//   total_cnt     resolved branches, saturating
//   miss_cnt      mispredicted branches, saturating
//   underflow_err sticky: resolution seen while the queue was empty
// -----------------------------------------------------------------------------
module branch_resolve_queue #(
   parameter int M     = 64,   // history table entries (at most 512: index comes from a 9-bit PC)
   parameter int DEPTH = 8,    // in-flight entries, power of two, >= 2
   parameter int CNT_W = 16    // accuracy counter width
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     pred_valid,
   input  logic [8:0]               pred_pc,
   input  logic                     pred_taken,
   output logic                     pred_ready,
   input  logic                     res_valid,
   input  logic                     res_taken,
   output logic                     upd_valid,
   output logic [$clog2(M)-1:0]     upd_index,
   output logic                     upd_taken,
   output logic                     mispredict,
   output logic [$clog2(DEPTH):0]   occupancy,
   output logic [CNT_W-1:0]         total_cnt,
   output logic [CNT_W-1:0]         miss_cnt,
   output logic                     underflow_err
);

   localparam int ADDR_BITS = $clog2(M);
   localparam int PTR_W     = $clog2(DEPTH);
   localparam int OCC_W     = PTR_W + 1;

   localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(DEPTH);
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;
   localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
   localparam logic [OCC_W-1:0] OCC_ONE  = OCC_W'(1);

   // Each entry is {table index, predicted direction}. The head entry is read
   // combinationally so a mispredict can flush on the same edge as the pop.
   logic [ADDR_BITS:0]   mem [DEPTH];
   logic [PTR_W-1:0]     wr_ptr_reg;
   logic [PTR_W-1:0]     rd_ptr_reg;
   logic [OCC_W-1:0]     occ_reg;

   logic [ADDR_BITS:0]   head_entry;
   logic [ADDR_BITS-1:0] head_index;
   logic                 head_taken;
   logic                 queue_empty;
   logic                 push_req;
   logic                 pop_en;
   logic                 miss_en;
   logic                 push_en;

   // Only the low PC bits address the table; the rest are intentionally unused.
   generate
      if (ADDR_BITS < 9) begin : g_pc_unused
         logic unused_pc_bits;
         assign unused_pc_bits = ^pred_pc[8:ADDR_BITS];
      end
   endgenerate

   assign head_entry  = mem[rd_ptr_reg];
   assign head_index  = head_entry[ADDR_BITS:1];
   assign head_taken  = head_entry[0];

   assign queue_empty = (occ_reg == '0);
   // No full bypass: a pop in the same cycle does not make room for a push.
   assign pred_ready  = (occ_reg != OCC_FULL);
   assign occupancy   = occ_reg;

   assign push_req    = pred_valid && pred_ready;
   assign pop_en      = res_valid && !queue_empty;
   assign miss_en     = pop_en && (head_taken != res_taken);
   // A push arriving alongside a mispredict is on the wrong path.
   assign push_en     = push_req && !miss_en;

   always_ff @(posedge clk) begin
      if (push_en) begin
         mem[wr_ptr_reg] <= {pred_pc[ADDR_BITS-1:0], pred_taken};
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         occ_reg    <= '0;
      end else begin
         if (push_en) begin
            wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
         end
         if (miss_en) begin
            // Flush: everything younger than the mispredicted branch is dropped.
            // The write pointer does not move (the concurrent push was dropped).
            rd_ptr_reg <= wr_ptr_reg;
            occ_reg    <= '0;
         end else begin
            if (pop_en) begin
               rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
            end
            case ({push_en, pop_en})
               2'b10:   occ_reg <= occ_reg + OCC_ONE;
               2'b01:   occ_reg <= occ_reg - OCC_ONE;
               default: occ_reg <= occ_reg;
            endcase
         end
      end
   end

   // Write-back and statistics are all registered from the pop edge, so the
   // counters show their new values in the same cycle as upd_valid.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         upd_valid     <= 1'b0;
         upd_index     <= '0;
         upd_taken     <= 1'b0;
         mispredict    <= 1'b0;
         total_cnt     <= '0;
         miss_cnt      <= '0;
         underflow_err <= 1'b0;
      end else begin
         upd_valid  <= pop_en;
         mispredict <= miss_en;
         if (pop_en) begin
            upd_index <= head_index;
            upd_taken <= res_taken;
            if (total_cnt != CNT_MAX) begin
               total_cnt <= total_cnt + 1'b1;
            end
         end
         if (miss_en && (miss_cnt != CNT_MAX)) begin
            miss_cnt <= miss_cnt + 1'b1;
         end
         if (res_valid && queue_empty) begin
            underflow_err <= 1'b1;
         end
      end
   end

endmodule
